// File: rtl/mem_stage.sv
// mem_stage: load/store unit between ALU and writeback, with a req/gnt data-memory port and a valid/ready writeback port.
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready              upstream op handshake; fields below are captured on accept
//   alu_result, store_data         address or result, and store value
//   mem_read, mem_write, funct3    op kind, access size and sign
//   rd_in, reg_write_in            destination register and its write enable
//   dmem_req/we/addr/wdata/be      data-memory request (word-aligned address)
//   dmem_gnt, dmem_rvalid, dmem_rdata  data-memory grant and read response
//   wb_valid/wb_ready              writeback handshake
//   wb_data, wb_rd, wb_we, wb_misalign  writeback payload
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic        wb_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
    state_t      state;
    logic [31:0] addr, sd;
    logic [2:0]  f3;
    logic        rw, ld, mis;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val;
    assign in_ready   = state == IDLE;
    assign wb_valid   = state == OUT;
    assign dmem_req   = state == REQ;
    assign dmem_we    = dmem_req & ~ld;
    assign dmem_addr  = {addr[31:2], 2'b00};
    assign dmem_wdata = f3[1:0] == 2'b00 ? {4{sd[7:0]}} : f3[1:0] == 2'b01 ? {2{sd[15:0]}} : sd;
    assign dmem_be    = ld ? 4'hf : f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                        f3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'hf;
    // Unsupported size encodings are reported as misaligned so they never reach memory.
    assign mis = funct3 == 3'b011 || funct3[2:1] == 2'b11 ||
                 (funct3[1:0] == 2'b01 && alu_result[0]) ||
                 (funct3[1:0] == 2'b10 && |alu_result[1:0]);
    assign byte_sel = dmem_rdata[{addr[1:0], 3'b000} +: 8];
    assign half_sel = dmem_rdata[{addr[1], 4'b0000} +: 16];
    // funct3[2] selects zero-extension (LBU/LHU).
    assign ld_val = f3[1:0] == 2'b00 ? {{24{byte_sel[7] & ~f3[2]}}, byte_sel} :
                    f3[1:0] == 2'b01 ? {{16{half_sel[15] & ~f3[2]}}, half_sel} : dmem_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            sd          <= '0;
            f3          <= '0;
            rw          <= 1'b0;
            ld          <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_we       <= 1'b0;
            wb_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    addr        <= alu_result;
                    sd          <= store_data;
                    f3          <= funct3;
                    ld          <= mem_read;
                    // A write to x0 is dropped here so wb_we can never go high with wb_rd=0.
                    rw          <= reg_write_in & |rd_in;
                    wb_rd       <= rd_in;
                    wb_data     <= alu_result;
                    wb_misalign <= (mem_read | mem_write) & mis;
                    wb_we       <= ~(mem_read | mem_write) & reg_write_in & |rd_in;
                    state       <= (mem_read | mem_write) & ~mis ? REQ : OUT;
                end
                REQ:  if (dmem_gnt) state <= ld ? WAIT : OUT;
                WAIT: if (dmem_rvalid) begin
                    wb_data <= ld_val;
                    wb_we   <= rw;
                    state   <= OUT;
                end
                OUT:  if (wb_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
